// File: rtl/br_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : br_pkg                                                      |
// | Description : Shared types and defaults for the br_param register file.   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package br_pkg;

    typedef enum logic [0:0] {
        BR_IDLE  = 1'b0,
        BR_CLEAR = 1'b1
    } br_state_t;

    localparam int BR_WIDTH_DEF = 8;
    localparam int BR_DEPTH_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/br_read_port.sv
// +--------------------------------------------------------------------------+
// | Module      : br_read_port                                                |
// | Description : Registered read mux with range check, hold on !en,          |
// |               zero while busy and optional write-to-read forwarding.      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module br_read_port #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_busy,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_mem [DEPTH],
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_data
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic             w_in_range;
    logic             w_hit;
    logic [WIDTH-1:0] r_data;

    assign w_in_range = ({1'b0, i_addr} < c_DEPTH);
    // i_wr_en is already qualified (idle, enabled, in range) by the owner of the array
    assign w_hit      = BYPASS && i_wr_en && (i_wr_addr == i_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_busy) begin
            r_data <= '0;
        end else if (i_en) begin
            if (!w_in_range) begin
                r_data <= '0;
            end else if (w_hit) begin
                r_data <= i_wr_data;
            end else begin
                r_data <= i_mem[i_addr];
            end
        end
    end

    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/br_param.sv
// +--------------------------------------------------------------------------+
// | Module      : br_param                                                    |
// | Description : WIDTH x DEPTH register file, one write port, two registered |
// |               read ports, sequential clear sweep with Busy flag.          |
// |               Define BR_BYPASS_EN for write-to-read forwarding.           |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module br_param
    import br_pkg::*;
#(
    parameter int WIDTH = BR_WIDTH_DEF,
    parameter int DEPTH = BR_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic             WE,
    input  logic [AW-1:0]    Dir_w,
    input  logic [WIDTH-1:0] Dato_e,
    input  logic [AW-1:0]    Dir_a,
    input  logic [AW-1:0]    Dir_b,
    input  logic             Clr,
    output logic [WIDTH-1:0] Dato_a,
    output logic [WIDTH-1:0] Dato_b,
    output logic             Busy
);

    localparam logic [0:0]    c_ST_IDLE  = BR_IDLE;
    localparam logic [0:0]    c_ST_CLEAR = BR_CLEAR;
    localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST     = AW'(DEPTH - 1);

`ifdef BR_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]       r_state;
    logic [AW-1:0]    r_ptr;
    logic             w_busy;
    logic             w_wr_ok;

    assign w_busy  = (r_state == c_ST_CLEAR);
    assign w_wr_ok = En && WE && !w_busy && ({1'b0, Dir_w} < c_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (Clr) begin
                        r_state <= c_ST_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                c_ST_CLEAR: begin
                    if (r_ptr == c_LAST) begin
                        r_state <= c_ST_IDLE;
                    end
                    r_ptr <= r_ptr + AW'(1);
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // A write coinciding with Clr lands first; the sweep that follows zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_busy) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[Dir_w] <= Dato_e;
        end
    end

    br_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .BYPASS (c_BYPASS)
    ) u_rd_a (
        .clk       (clk),
        .rst       (rst),
        .i_en      (En),
        .i_busy    (w_busy),
        .i_addr    (Dir_a),
        .i_mem     (r_mem),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (Dir_w),
        .i_wr_data (Dato_e),
        .o_data    (Dato_a)
    );

    br_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .BYPASS (c_BYPASS)
    ) u_rd_b (
        .clk       (clk),
        .rst       (rst),
        .i_en      (En),
        .i_busy    (w_busy),
        .i_addr    (Dir_b),
        .i_mem     (r_mem),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (Dir_w),
        .i_wr_data (Dato_e),
        .o_data    (Dato_b)
    );

    assign Busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_br_param.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_br_param                                                 |
// | Description : Self-checking bench for br_param at DEPTH=4 and DEPTH=5,    |
// |               directed steps followed by random traffic.                  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_br_param;

`ifdef BR_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, we, clr;
    logic [2:0] dir_w, dir_a, dir_b;
    logic [7:0] dato_e;
    logic [7:0] qa4, qb4, qa5, qb5;
    logic       busy4, busy5;

    always #5 clk = ~clk;

    br_param #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .En(en), .WE(we), .Dir_w(dir_w[1:0]), .Dato_e(dato_e),
        .Dir_a(dir_a[1:0]), .Dir_b(dir_b[1:0]), .Clr(clr),
        .Dato_a(qa4), .Dato_b(qb4), .Busy(busy4)
    );

    br_param #(.WIDTH(8), .DEPTH(5)) u_d5 (
        .clk(clk), .rst(rst), .En(en), .WE(we), .Dir_w(dir_w), .Dato_e(dato_e),
        .Dir_a(dir_a), .Dir_b(dir_b), .Clr(clr),
        .Dato_a(qa5), .Dato_b(qb5), .Busy(busy5)
    );

    // Reference model: index 0 is the DEPTH=4 instance, index 1 the DEPTH=5 one.
    int depth [2] = '{4, 5};
    int mem   [2][8];
    int ea    [2];
    int eb    [2];
    int bleft [2];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic int amask(int k, logic [2:0] a);
        logic [1:0] lo;
        lo = a[1:0];
        return (k == 0) ? int'(lo) : int'(a);
    endfunction

    function automatic int rd(int k, int a, int w, bit wr);
        if (a >= depth[k]) return 0;
        if (c_BYP && wr && a == w) return int'(dato_e);
        return mem[k][a];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int  w, a, b;
            bit  busy, wr;
            w    = amask(k, dir_w);
            a    = amask(k, dir_a);
            b    = amask(k, dir_b);
            busy = (bleft[k] > 0);
            if (rst) begin
                for (int i = 0; i < 8; i++) mem[k][i] = 0;
                ea[k] = 0; eb[k] = 0; bleft[k] = 0;
            end else begin
                wr = en && we && !busy && (w < depth[k]);
                if (busy) begin
                    ea[k] = 0; eb[k] = 0;
                end else if (en) begin
                    ea[k] = rd(k, a, w, wr);
                    eb[k] = rd(k, b, w, wr);
                end
                if (wr) mem[k][w] = int'(dato_e);
                if (busy) begin
                    mem[k][depth[k] - bleft[k]] = 0;
                    bleft[k]--;
                end else if (clr) begin
                    bleft[k] = depth[k];
                end
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("d4_dato_a", 32'(qa4), ea[0]);
        check("d4_dato_b", 32'(qb4), eb[0]);
        check("d4_busy",   32'(busy4), 32'(bleft[0] > 0));
        check("d5_dato_a", 32'(qa5), ea[1]);
        check("d5_dato_b", 32'(qb5), eb[1]);
        check("d5_busy",   32'(busy5), 32'(bleft[1] > 0));
    endtask

    initial begin
        int hi4, hi5, cnt;
        rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0;
        dir_w = '0; dir_a = '0; dir_b = '0; dato_e = '0;
        for (int k = 0; k < 2; k++) begin
            ea[k] = 0; eb[k] = 0; bleft[k] = 0;
            for (int i = 0; i < 8; i++) mem[k][i] = 0;
        end
        step();
        check("reset_dato_a", 32'(qa4), 0);
        check("reset_busy", 32'(busy4), 0);
        rst = 1'b0;

        // Fill 10/20/30/40, then read crosswise
        en = 1'b1; we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dir_w = 3'(i); dato_e = 8'(10 * (i + 1));
            step();
        end
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dir_a = 3'(i); dir_b = 3'(3 - i);
            step();
            check("dflt_a", 32'(qa4), 10 * (i + 1));
            check("dflt_b", 32'(qb4), 10 * (4 - i));
        end

        // Read during write on register 2
        we = 1'b1; dir_w = 3'd2; dato_e = 8'd99; dir_a = 3'd2;
        step();
        check("rdw_same_edge", 32'(qa4), c_BYP ? 99 : 30);
        we = 1'b0;
        step();
        check("rdw_next", 32'(qa4), 99);
        we = 1'b1; dato_e = 8'd30;
        step();
        we = 1'b0;

        // Clear sweep with a write attempted while busy
        clr = 1'b1;
        step();
        clr = 1'b0;
        hi4 = busy4 ? 1 : 0;
        hi5 = busy5 ? 1 : 0;
        cnt = 0;
        we = 1'b1; dir_w = 3'd1; dato_e = 8'd55;
        while ((busy4 || busy5) && cnt < 20) begin
            if (cnt == 2) we = 1'b0;
            step();
            cnt++;
            if (busy4) hi4++;
            if (busy5) hi5++;
        end
        we = 1'b0;
        check("busy_len_d4", 32'(hi4), 4);
        check("busy_len_d5", 32'(hi5), 5);
        for (int i = 0; i < 5; i++) begin
            dir_a = 3'(i); dir_b = 3'(i);
            step();
            check("clr_zero", 32'(qa5), 0);
        end

        // Enable hold
        we = 1'b1; dir_w = 3'd1; dato_e = 8'd20;
        step();
        we = 1'b0; dir_a = 3'd1;
        step();
        check("en_pre", 32'(qa4), 20);
        en = 1'b0; we = 1'b1; dir_a = 3'd3; dir_w = 3'd1; dato_e = 8'd123;
        step();
        step();
        check("en_hold", 32'(qa4), 20);
        en = 1'b1; we = 1'b0; dir_a = 3'd1;
        step();
        check("en_nowrite", 32'(qa4), 20);

        // Out-of-range write/read on DEPTH=5
        we = 1'b1; dir_w = 3'd6; dato_e = 8'd7;
        step();
        dir_w = 3'd4; dato_e = 8'd77;
        step();
        we = 1'b0; dir_a = 3'd6; dir_b = 3'd4;
        step();
        check("d5_oor_read", 32'(qa5), 0);
        check("d5_addr4", 32'(qb5), 77);
        for (int i = 0; i < 5; i++) begin
            dir_a = 3'(i);
            step();
        end

        // Reset in the second busy cycle
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rst_mid_busy", 32'(busy4), 0);
        check("rst_mid_a", 32'(qa4), 0);
        check("rst_mid_b", 32'(qb4), 0);
        rst = 1'b0; we = 1'b1; dir_w = 3'd3; dato_e = 8'd66;
        step();
        we = 1'b0; dir_a = 3'd3;
        step();
        check("post_rst_rw", 32'(qa4), 66);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 63) == 0);
            clr    = ($urandom_range(0, 15) == 0);
            en     = ($urandom_range(0, 3) != 0);
            we     = $urandom_range(0, 1) == 1;
            dir_w  = 3'($urandom);
            dir_a  = 3'($urandom);
            dir_b  = ($urandom_range(0, 3) == 0) ? dir_a : 3'($urandom);
            dato_e = 8'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/br_param.md
Name: br_param

Overview:
- Parametrised successor to the 4x8 single-port register bank.
- Generic WIDTH x DEPTH register file: one write port, two independent registered read ports, and a sequential clear engine with a Busy flag.
- Sits in the datapath as the general-purpose register file feeding ALU operands A and B.

Parameters:
- WIDTH, 8: data bits per register.
- DEPTH, 4: number of registers; need not be a power of two, minimum 2.
- AW, $clog2(DEPTH): address width; derived, do not override.

Ports:
- clk    input   1      rising-edge clock.
- rst    input   1      reset; synchronous, active-high.
- En     input   1      global enable; when 0, no write or read update occurs (Clr still accepted).
- WE     input   1      write enable; qualified by En.
- Dir_w  input   AW     write address.
- Dato_e input   WIDTH  write data.
- Dir_a  input   AW     read address, port A.
- Dir_b  input   AW     read address, port B.
- Clr    input   1      one-cycle request to zero every register.
- Dato_a output  WIDTH  registered read data, port A.
- Dato_b output  WIDTH  registered read data, port B.
- Busy   output  1      high while a clear sweep is in progress.

Behaviour:
- Reset (rst=1 at an edge): all DEPTH registers go to 0; Dato_a=0, Dato_b=0, Busy=0; FSM goes to IDLE. Reset overrides every other input, including a sweep in progress.
- FSM states:
  - IDLE: Busy=0. Normal operation.
  - CLEAR: Busy=1. A pointer ptr walks 0..DEPTH-1.
- IDLE -> CLEAR: when Clr=1 is sampled; ptr loads 0.
- In CLEAR: each edge writes reg[ptr]=0 and increments ptr. On the edge that clears ptr=DEPTH-1, the FSM returns to IDLE.
- Busy is high for exactly DEPTH cycles after the Clr edge.
- Clr asserted while already in CLEAR is ignored; the sweep does not restart.
- Write: on an edge with En=1, WE=1, FSM in IDLE and Dir_w<DEPTH, reg[Dir_w] takes Dato_e. Writes are dropped while Busy=1.
- Clr and WE in the same IDLE cycle: the write is performed, then the sweep zeroes it. Net result: all zeros.
- Read:
  - Latency is 1 cycle. On an edge with En=1, Dato_a takes reg[Dir_a] and Dato_b takes reg[Dir_b], using the array contents before that edge's write.
  - En=0: Dato_a and Dato_b hold their values.
  - Busy=1: Dato_a and Dato_b are loaded with 0 regardless of En.
- Out-of-range address (any address >= DEPTH): a write is ignored; a read returns 0.
- Read-during-write to the same address, without the optional feature: the read returns the old contents.
- Both read ports may address the same register; both return identical data.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: BR_BYPASS_EN.
- Defined: write-to-read forwarding. When a write qualifies on an edge and Dir_a==Dir_w (or Dir_b==Dir_w), that port loads Dato_e on the same edge instead of the old contents.
- Undefined: old-contents read-during-write, as described in Behaviour.
- Forwarding never applies while Busy=1 or to out-of-range addresses.

Decomposition:
- Shared package br_pkg holds:
  - FSM state enum br_state_t {BR_IDLE, BR_CLEAR}.
  - Default constants BR_WIDTH_DEF=8 and BR_DEPTH_DEF=4.
- One sub-module is natural: br_read_port (a registered read mux with range check, hold-on-!En, zero-on-Busy and optional bypass), instantiated twice for ports A and B.
- Storage array, write logic and the clear FSM stay in br_param.

Test Plan:
- Defaults. With En=1, WE=1, write 10, 20, 30, 40 to addresses 0..3. Then set WE=0, Dir_a=0..3, Dir_b=3..0. Required: one cycle later each, Dato_a reads 10, 20, 30, 40 and Dato_b reads 40, 30, 20, 10.
- Read-during-write. Register 2 holds 30. Write 99 to address 2 while Dir_a=2. Required: Dato_a=30 without BR_BYPASS_EN, 99 with it. Next cycle Dato_a=99 in both builds.
- Clear sweep. Fill with 10/20/30/40, pulse Clr. Required: Busy=1 for exactly 4 cycles; a write of 55 to address 1 during Busy is dropped; after Busy falls, all reads return 0.
- En hold. Dato_a=20, then drop En and change Dir_a and Dato_e with WE=1. Required: Dato_a stays 20 and no register changes.
- Non-power-of-two (DEPTH=5). Write 7 to address 6. Required: no register changes. Reading address 6 gives 0; reading address 4 after writing 77 gives 77.
- Reset mid-clear. Assert rst in the 2nd Busy cycle. Required: the next edge gives Busy=0, Dato_a=0 and Dato_b=0; a subsequent write and read work normally.
